// File: rtl/store_buffer_if.sv
// Store-buffer bus: MEM-stage store/load requests on one side, DATA_MEM write port on the other.
interface store_buffer_if #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          ld_stall;
  logic          flush;
  logic          empty;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, flush,
    input  st_ready, ld_hit, ld_data, ld_stall, empty, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, flush,
    output st_ready, ld_hit, ld_data, ld_stall, empty, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store queue draining into DATA_MEM when loads leave the port idle.
// Define STB_FORWARD_EN to forward pending store data to loads instead of stalling them.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64
) (
  input  logic           CLK,
  input  logic           RESET,
  store_buffer_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          flush_pend_q;

  logic          empty_int;
  logic          any_match;
  logic [DW-1:0] match_data;
  logic [PW-1:0] idx;
  logic          hit, stall, drain, push, ready;

  assign empty_int = (count_q == '0);

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    any_match  = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == bus.ld_addr)) begin
        any_match  = 1'b1;
        match_data = data_q[idx];
      end
    end
  end

`ifdef STB_FORWARD_EN
  assign hit   = !RESET && bus.ld_req && any_match;
  assign stall = 1'b0;
  assign drain = !RESET && !empty_int && !bus.ld_req;
`else
  assign hit   = 1'b0;
  assign stall = !RESET && bus.ld_req && any_match;
  // A stalled load keeps ld_req high, so the drain must ignore it or it would deadlock.
  assign drain = !RESET && !empty_int && (!bus.ld_req || stall);
`endif

  assign ready = !RESET && (count_q < CW'(DEPTH)) && !flush_pend_q && !bus.flush;
  assign push  = bus.st_valid && ready;

  assign bus.st_ready  = ready;
  assign bus.ld_hit    = hit;
  assign bus.ld_data   = hit ? match_data : '0;
  assign bus.ld_stall  = stall;
  assign bus.empty     = RESET || empty_int;
  assign bus.mem_write = drain;
  assign bus.mem_addr  = addr_q[head_q];
  assign bus.mem_wdata = data_q[head_q];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (push)  tail_q <= tail_q + PW'(1);
      if (drain) head_q <= head_q + PW'(1);
      count_q      <= count_q + CW'(push) - CW'(drain);
      flush_pend_q <= empty_int ? 1'b0 : (flush_pend_q | bus.flush);
    end
  end

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  store_buffer_if #(.AW(AW), .DW(DW)) sb ();
  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.CLK(CLK), .RESET(RESET), .bus(sb.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct { logic [63:0] a; logic [63:0] d; } ent_t;
  ent_t        q[$];
  bit          fp = 1'b0;
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] dmem    [logic [63:0]];
  logic [63:0] drained [$];

  function automatic void model_out(output logic e_ready, output logic e_empty,
                                    output logic e_hit, output logic e_stall,
                                    output logic e_mw, output logic [63:0] e_data);
    bit found = 1'b0;
    logic [63:0] yd = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == sb.ld_addr) begin
        found = 1'b1;
        yd    = q[i].d;
        break;
      end
    end
    e_ready = !RESET && (q.size() < DEPTH) && !fp && !sb.flush;
    e_empty = RESET || (q.size() == 0);
`ifdef STB_FORWARD_EN
    e_hit   = !RESET && sb.ld_req && found;
    e_stall = 1'b0;
    e_mw    = !RESET && (q.size() != 0) && !sb.ld_req;
`else
    e_hit   = 1'b0;
    e_stall = !RESET && sb.ld_req && found;
    e_mw    = !RESET && (q.size() != 0) && (!sb.ld_req || e_stall);
`endif
    e_data  = e_hit ? yd : '0;
  endfunction

  // Mid-cycle: compare against the model, record the DATA_MEM write, then advance the model.
  always @(negedge CLK) begin
    logic e_ready, e_empty, e_hit, e_stall, e_mw;
    logic [63:0] e_data;
    bit push;
    model_out(e_ready, e_empty, e_hit, e_stall, e_mw, e_data);
    chk("st_ready", sb.st_ready, e_ready);
    chk("empty", sb.empty, e_empty);
    chk("ld_hit", sb.ld_hit, e_hit);
    chk("ld_stall", sb.ld_stall, e_stall);
    chk("ld_data", sb.ld_data, e_data);
    chk("mem_write", sb.mem_write, e_mw);
    if (e_mw) begin
      chk("mem_addr", sb.mem_addr, q[0].a);
      chk("mem_wdata", sb.mem_wdata, q[0].d);
    end
    if (sb.mem_write === 1'b1) begin
      dmem[sb.mem_addr] = sb.mem_wdata;
      drained.push_back(sb.mem_addr);
    end
    if (RESET) begin
      q.delete();
      fp = 1'b0;
    end else begin
      push = sb.st_valid && e_ready;
      fp   = (q.size() == 0) ? 1'b0 : (fp | sb.flush);
      if (e_mw) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (push) q.push_back('{a: sb.st_addr, d: sb.st_data});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    sb.st_valid = 1'b1;
    sb.st_addr  = a;
    sb.st_data  = d;
    tick();
    sb.st_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    RESET       = 1'b1;
    sb.st_valid = 1'b0;
    sb.st_addr  = '0;
    sb.st_data  = '0;
    sb.ld_req   = 1'b0;
    sb.ld_addr  = '0;
    sb.flush    = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_empty", sb.empty, 1);
    chk("rst_ready", sb.st_ready, 0);
    chk("rst_mem_write", sb.mem_write, 0);
    RESET = 1'b0;
    #1;
    chk("post_rst_ready", sb.st_ready, 1);

    // 1: four back-to-back stores drain in order
    drained.delete();
    for (int i = 0; i < 4; i++) begin
      sb.st_valid = 1'b1;
      sb.st_addr  = 64'(i);
      sb.st_data  = 64'((i + 1) * 'h11);
      #1;
      chk("t1_ready", sb.st_ready, 1);
      tick();
    end
    sb.st_valid = 1'b0;
    repeat (6) tick();
    chk("t1_count", 64'(drained.size()), 4);
    for (int i = 0; i < 4 && i < drained.size(); i++) chk("t1_order", drained[i], 64'(i));
    chk("t1_dmem3", dmem.exists(64'd3) ? dmem[64'd3] : '0, 64'h44);
    chk("t1_empty", sb.empty, 1);

    // 2: load blocks the drain; fifth store refused until space frees
    drained.delete();
    sb.ld_req  = 1'b1;
    sb.ld_addr = 64'h100;
    for (int i = 0; i < 4; i++) store(64'h200 + 64'(i), 64'h2000 + 64'(i));
    sb.st_valid = 1'b1;
    sb.st_addr  = 64'h204;
    sb.st_data  = 64'h2004;
    #1;
    chk("t2_full_ready", sb.st_ready, 0);
    chk("t2_no_write", sb.mem_write, 0);
    tick();
    sb.ld_req = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      #1;
      if (sb.st_ready) acc = 1'b1;
      tick();
    end
    sb.st_valid = 1'b0;
    chk("t2_accepted", acc, 1);
    repeat (8) tick();
    chk("t2_count", 64'(drained.size()), 5);
    for (int i = 0; i < 5 && i < drained.size(); i++)
      chk("t2_order", drained[i], 64'h200 + 64'(i));

`ifdef STB_FORWARD_EN
    // 3: youngest matching entry forwarded
    sb.ld_req  = 1'b1;
    sb.ld_addr = 64'h100;
    store(64'd7, 64'hAAAA);
    store(64'd7, 64'hBBBB);
    sb.ld_addr = 64'd7;
    #1;
    chk("t3_hit", sb.ld_hit, 1);
    chk("t3_data", sb.ld_data, 64'hBBBB);
    sb.ld_addr = 64'd8;
    #1;
    chk("t3_miss", sb.ld_hit, 0);
    chk("t3_miss_data", sb.ld_data, 0);
    tick();
    sb.ld_req = 1'b0;
    repeat (4) tick();
    chk("t3_dmem7", dmem.exists(64'd7) ? dmem[64'd7] : '0, 64'hBBBB);
`else
    // 4: matching load stalls and forces the drain
    store(64'd5, 64'h5555);
    sb.ld_req  = 1'b1;
    sb.ld_addr = 64'd5;
    #1;
    chk("t4_stall", sb.ld_stall, 1);
    chk("t4_mem_write", sb.mem_write, 1);
    chk("t4_mem_addr", sb.mem_addr, 5);
    tick();
    #1;
    chk("t4_stall_clear", sb.ld_stall, 0);
    chk("t4_dmem5", dmem.exists(64'd5) ? dmem[64'd5] : '0, 64'h5555);
    sb.ld_req = 1'b0;
    tick();
`endif

    // 5: flush drains three entries while refusing stores
    drained.delete();
    sb.ld_req  = 1'b1;
    sb.ld_addr = 64'h100;
    for (int i = 0; i < 3; i++) store(64'h500 + 64'(i), 64'h5000 + 64'(i));
    sb.ld_req = 1'b0;
    sb.flush  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (sb.empty) break;
      chk("t5_ready_low", sb.st_ready, 0);
      tick();
      sb.flush = 1'b0;
    end
    sb.flush = 1'b0;
    chk("t5_empty", sb.empty, 1);
    chk("t5_pulses", 64'(drained.size()), 3);
    repeat (3) tick();

    // 6: reset discards pending stores
    drained.delete();
    sb.ld_req  = 1'b1;
    sb.ld_addr = 64'h100;
    store(64'h600, 64'h6000);
    store(64'h601, 64'h6001);
    sb.ld_req = 1'b0;
    do_reset();
    #1;
    chk("t6_empty", sb.empty, 1);
    chk("t6_mem_write", sb.mem_write, 0);
    repeat (4) tick();
    chk("t6_no_writes", 64'(drained.size()), 0);
    chk("t6_dmem600", 64'(dmem.exists(64'h600)), 0);
    chk("t6_dmem601", 64'(dmem.exists(64'h601)), 0);

    chk("final_dmem_size", 64'(dmem.size()), 64'(ref_mem.size()));
    foreach (ref_mem[k]) begin
      if (dmem.exists(k)) chk("final_dmem", dmem[k], ref_mem[k]);
      else chk("final_dmem_exists", 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
